// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port SRAM among NumReq requesters
// Ports: clk_i/rst_i clock and async active-high reset; req_i/we_i/addr_i/wdata_i/wmask_i
// packed requester fields; gnt_o one-hot grant; rdata_o/rvalid_o routed read response;
// ram_* SRAM macro side; err_o sticky unexpected/lost response flag.
// Optional SRAM_ARB_BURST_HOLD_EN keeps granting a requester for up to MaxHold cycles.
module sram_arbiter #(
  parameter int NumReq  = 2,
  parameter int Aw      = 12,
  parameter int Dw      = 32,
  parameter int Latency = 1,
  parameter int MaxHold = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq-1:0]    we_i,
  input  logic [NumReq*Aw-1:0] addr_i,
  input  logic [NumReq*Dw-1:0] wdata_i,
  input  logic [NumReq*Dw-1:0] wmask_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [Dw-1:0]        rdata_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [Aw-1:0]        ram_addr_o,
  output logic [Dw-1:0]        ram_wdata_o,
  output logic [Dw-1:0]        ram_wmask_o,
  input  logic [Dw-1:0]        ram_rdata_i,
  input  logic                 ram_rvalid_i,
  output logic                 err_o
);
  localparam int Pw = $clog2(NumReq);
  if (NumReq < 2 || NumReq > 8 || Latency < 1 || Latency > 4 || MaxHold < 1) begin : g_bad
    $error("sram_arbiter: parameter out of range");
  end
  logic [Pw-1:0] r_ptr;
  logic [Pw-1:0] w_rr_win;
  logic          w_rr_any;
  logic [Pw-1:0] w_win;
  logic          w_any;
  logic [Latency-1:0] r_pv;
  logic [Pw-1:0]      r_pi [Latency];
  logic               r_err;
  logic               w_lv;
  logic [Pw-1:0]      w_li;
  always_comb begin
    w_rr_win = '0;
    w_rr_any = 1'b0;
    for (int o = NumReq - 1; o >= 0; o--) begin
      if (req_i[(int'(r_ptr) + o) % NumReq]) begin
        w_rr_win = Pw'((int'(r_ptr) + o) % NumReq);
        w_rr_any = 1'b1;
      end
    end
  end
`ifdef SRAM_ARB_BURST_HOLD_EN
  localparam int Hw = $clog2(MaxHold + 1);
  logic [Pw-1:0] r_hold_idx;
  logic [Hw-1:0] r_hold_cnt;
  logic          w_hold;
  assign w_hold = r_hold_cnt != '0 && r_hold_cnt < Hw'(MaxHold) && req_i[r_hold_idx];
  assign w_win  = w_hold ? r_hold_idx : w_rr_win;
  assign w_any  = (w_hold | w_rr_any) & ~rst_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_idx <= '0;
      r_hold_cnt <= '0;
    end else if (!w_any) begin
      r_hold_cnt <= '0;
    end else if (w_hold) begin
      r_hold_cnt <= r_hold_cnt + Hw'(1);
    end else begin
      r_hold_idx <= w_win;
      r_hold_cnt <= Hw'(1);
    end
  end
`else
  assign w_win = w_rr_win;
  assign w_any = w_rr_any & ~rst_i;
`endif
  assign gnt_o       = w_any ? (NumReq'(1) << w_win) : '0;
  assign ram_req_o   = w_any;
  assign ram_we_o    = w_any & we_i[w_win];
  assign ram_addr_o  = w_any ? addr_i[int'(w_win)*Aw +: Aw] : '0;
  assign ram_wdata_o = w_any ? wdata_i[int'(w_win)*Dw +: Dw] : '0;
  assign ram_wmask_o = w_any ? wmask_i[int'(w_win)*Dw +: Dw] : '0;
  assign w_lv     = r_pv[Latency-1];
  assign w_li     = r_pi[Latency-1];
  assign rvalid_o = (ram_rvalid_i && w_lv) ? (NumReq'(1) << w_li) : '0;
  assign rdata_o  = ram_rdata_i;
  assign err_o    = r_err;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_pv  <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < Latency; k++) r_pi[k] <= '0;
    end else begin
      if (w_any) r_ptr <= (w_win == Pw'(NumReq - 1)) ? '0 : w_win + Pw'(1);
      r_pv[0] <= w_any & ~we_i[w_win];
      r_pi[0] <= w_win;
      for (int k = Latency - 1; k > 0; k--) begin
        r_pv[k] <= r_pv[k-1];
        r_pi[k] <= r_pi[k-1];
      end
      // a response with nothing outstanding, or an outstanding read with no response
      r_err <= r_err | (ram_rvalid_i != w_lv);
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with RAM models at latency 1 and 3
module tb_sram_arbiter;
  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic            rst_a, rst_b;
  logic [N-1:0]    req_a, we_a, gnt_a, rvalid_a;
  logic [N*AW-1:0] addr_a;
  logic [N*DW-1:0] wdata_a, wmask_a;
  logic [DW-1:0]   rdata_a, ram_wdata_a, ram_wmask_a, ram_rdata_a;
  logic [AW-1:0]   ram_addr_a;
  logic            ram_req_a, ram_we_a, ram_rvalid_a, err_a;
  logic [N-1:0]    req_b, we_b, gnt_b, rvalid_b;
  logic [N*AW-1:0] addr_b;
  logic [N*DW-1:0] wdata_b, wmask_b;
  logic [DW-1:0]   rdata_b, ram_wdata_b, ram_wmask_b, ram_rdata_b;
  logic [AW-1:0]   ram_addr_b;
  logic            ram_req_b, ram_we_b, ram_rvalid_b, err_b;
  sram_arbiter #(.NumReq(N), .Aw(AW), .Dw(DW), .Latency(1), .MaxHold(4)) u_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .wmask_i(wmask_a), .gnt_o(gnt_a), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .ram_req_o(ram_req_a), .ram_we_o(ram_we_a),
    .ram_addr_o(ram_addr_a), .ram_wdata_o(ram_wdata_a), .ram_wmask_o(ram_wmask_a),
    .ram_rdata_i(ram_rdata_a), .ram_rvalid_i(ram_rvalid_a), .err_o(err_a));
  sram_arbiter #(.NumReq(N), .Aw(AW), .Dw(DW), .Latency(3), .MaxHold(4)) u_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .wmask_i(wmask_b), .gnt_o(gnt_b), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .ram_req_o(ram_req_b), .ram_we_o(ram_we_b),
    .ram_addr_o(ram_addr_b), .ram_wdata_o(ram_wdata_b), .ram_wmask_o(ram_wmask_b),
    .ram_rdata_i(ram_rdata_b), .ram_rvalid_i(ram_rvalid_b), .err_o(err_b));
  logic [DW-1:0] mem [4096];
  logic          m_v, inj;
  logic [DW-1:0] m_d;
  always @(posedge clk) begin
    if (ram_req_a && ram_we_a) mem[ram_addr_a] <= (mem[ram_addr_a] & ~ram_wmask_a) | (ram_wdata_a & ram_wmask_a);
    m_v <= rst_a ? 1'b0 : (ram_req_a && !ram_we_a);
    m_d <= mem[ram_addr_a];
  end
  assign ram_rvalid_a = m_v | inj;
  assign ram_rdata_a  = m_d;
  logic [2:0] bv;
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) bv <= '0;
    else bv <= {bv[1:0], ram_req_b && !ram_we_b};
  end
  assign ram_rvalid_b = bv[2];
  assign ram_rdata_b  = 32'h12345678;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [N-1:0]  rv;
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_a && rvalid_a != '0) begin
      if (q.size() == 0) begin
        chk("rvalid_unexpected", 64'(rvalid_a), 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid_idx", 64'(rvalid_a), 64'(e.rv));
        chk("rdata", 64'(rdata_a), 64'(e.d));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end
  logic b_seen = 1'b0;
  always @(negedge clk) if (rvalid_b != '0) b_seen <= 1'b1;
  task automatic step(input logic [N-1:0] eg, input logic rd, input logic [DW-1:0] ed, input string nm);
    exp_t e;
    #1;
    chk(nm, 64'(gnt_a), 64'(eg));
    if (rd) begin
      e.rv  = eg;
      e.d   = ed;
      e.due = cyc + 1;
      q.push_back(e);
    end
  endtask
  logic [N-1:0] exp_rr [6];
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
`ifdef SRAM_ARB_BURST_HOLD_EN
    exp_rr = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`else
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 32'hDEADBEEF;
    rst_a = 1'b1; rst_b = 1'b1; inj = 1'b0;
    req_a = 2'b11; we_a = 2'b11; addr_a = {12'h020, 12'h010};
    wdata_a = {32'h11111111, 32'h22222222}; wmask_a = '1;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; wmask_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt_a), 64'h0);
    chk("rst_ram_req", 64'(ram_req_a), 64'h0);
    chk("rst_ram_we", 64'(ram_we_a), 64'h0);
    chk("rst_ram_addr", 64'(ram_addr_a), 64'h0);
    chk("rst_ram_wdata", 64'(ram_wdata_a), 64'h0);
    chk("rst_rvalid", 64'(rvalid_a), 64'h0);
    chk("rst_err", 64'(err_a), 64'h0);
    req_a = '0; we_a = '0; wmask_a = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    req_a = 2'b01; addr_a = {12'h000, 12'h010};
    step(2'b01, 1'b1, 32'hDEADBEEF, "t1_gnt");
    chk("t1_ram_addr", 64'(ram_addr_a), 64'h010);
    @(negedge clk);
    req_a = '0;
    step(2'b00, 1'b0, '0, "t1_idle_gnt");
    @(negedge clk);
    chk("t1_err", 64'(err_a), 64'h0);
    req_a = 2'b10; we_a = 2'b10; addr_a = {12'h020, 12'h000};
    wdata_a = {32'hA5A5A5A5, 32'h0}; wmask_a = {32'hFFFF0000, 32'h0};
    step(2'b10, 1'b0, '0, "t2_wr_gnt");
    chk("t2_ram_we", 64'(ram_we_a), 64'h1);
    chk("t2_ram_addr", 64'(ram_addr_a), 64'h020);
    chk("t2_ram_wdata", 64'(ram_wdata_a), 64'hA5A5A5A5);
    chk("t2_ram_wmask", 64'(ram_wmask_a), 64'hFFFF0000);
    @(negedge clk);
    we_a = '0;
    step(2'b10, 1'b1, 32'hA5A50000, "t2_rd_gnt");
    chk("t2_rd_ram_we", 64'(ram_we_a), 64'h0);
    @(negedge clk);
    req_a = '0; wdata_a = '0; wmask_a = '0;
    @(negedge clk);
    req_a = 2'b11; addr_a = {12'h020, 12'h010};
    for (int i = 0; i < 6; i++) begin
      step(exp_rr[i], 1'b1, exp_rr[i] == 2'b01 ? 32'hDEADBEEF : 32'hA5A50000, "t3_gnt");
      @(negedge clk);
    end
    req_a = '0;
    repeat (2) @(negedge clk);
    chk("t3_err", 64'(err_a), 64'h0);
    chk("t3_queue_drained", 64'(q.size()), 64'h0);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("t4_err_set", 64'(err_a), 64'h1);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", 64'(err_a), 64'h1);
    rst_a = 1'b1;
    #1;
    chk("t4_err_cleared", 64'(err_a), 64'h0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    req_b = 2'b01; addr_b = {12'h000, 12'h010};
    #1;
    chk("t5_gnt", 64'(gnt_b), 64'h1);
    @(negedge clk);
    req_b = '0; rst_b = 1'b1;
    #1;
    chk("t5_rst_gnt", 64'(gnt_b), 64'h0);
    chk("t5_rst_ram_req", 64'(ram_req_b), 64'h0);
    chk("t5_rst_rvalid", 64'(rvalid_b), 64'h0);
    chk("t5_rst_err", 64'(err_b), 64'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_err_after", 64'(err_b), 64'h0);
    chk("t5_no_rvalid", 64'(b_seen), 64'h0);
    chk("end_queue_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port SRAM macro (req/we/addr/wdata/wmask in, rdata/rvalid out, fixed read latency) between `NumReq` SRAM-style requesters, for example two `tlul_adapter_sram` instances in front of one RAM. It grants at most one request per cycle and steers the RAM read response back to the requester whose read produced it. It also flags unexpected responses.

## Interface
- `NumReq`, 2: number of requesters, 2..8.
- `Aw`, 12: address width.
- `Dw`, 32: data width; `wmask` is also `Dw` bits.
- `Latency`, 1: RAM read latency in cycles, from accepted read to `ram_rvalid_i`; 1..4.
- `MaxHold`, 4: burst-hold limit; used only with the configuration macro.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in NumReq: per-requester request.
- `we_i` in NumReq: per-requester write enable.
- `addr_i` in NumReq*Aw: packed addresses; requester i occupies `[i*Aw +: Aw]`.
- `wdata_i` in NumReq*Dw: packed write data.
- `wmask_i` in NumReq*Dw: packed bit write mask.
- `gnt_o` out NumReq: one-hot or zero grant.
- `rdata_o` out Dw: read data broadcast to all requesters; equals `ram_rdata_i`.
- `rvalid_o` out NumReq: per-requester read-data valid.
- `ram_req_o` out 1: request to the RAM.
- `ram_we_o` out 1: write enable to the RAM.
- `ram_addr_o` out Aw: address to the RAM.
- `ram_wdata_o` out Dw: write data to the RAM.
- `ram_wmask_o` out Dw: write mask to the RAM.
- `ram_rdata_i` in Dw: RAM read data.
- `ram_rvalid_i` in 1: RAM read valid.
- `err_o` out 1: sticky flag for an unexpected `ram_rvalid_i`.

## Operation
- **State:**
  - `ptr`: $clog2(NumReq) bits, the highest-priority requester.
  - Response pipe: `Latency` stages of {valid, idx}.
  - `err` flag.
  - With the macro: `hold_idx` and `hold_cnt`.
- **Arbitration (combinational):**
  - Scan requesters starting at `ptr`, wrapping modulo NumReq.
  - The first requester with `req_i` set is the winner; `gnt_o[winner]=1`.
  - No `req_i` set gives `gnt_o=0`.
- **Pointer update:** on any grant, `ptr <= winner+1`, wrapping NumReq-1 to 0. With no grant, `ptr` holds.
- **RAM side:**
  - `ram_req_o = |gnt_o`.
  - `ram_we_o`, `ram_addr_o`, `ram_wdata_o` and `ram_wmask_o` are muxed from the winner.
  - With no grant, these outputs are driven to 0.
- **Response tracking:**
  - Stage 0 captures {granted && !we of winner, winner}.
  - The pipe shifts every cycle.
  - Writes enter the pipe as valid=0.
- **Response routing:**
  - `rvalid_o[i] = ram_rvalid_i && last.valid && last.idx==i`.
  - `rdata_o = ram_rdata_i` unconditionally.
- **Error:**
  - `ram_rvalid_i=1` while `last.valid=0` sets `err_o`. It stays set until reset.
  - `last.valid=1` with `ram_rvalid_i=0` also sets `err_o` (lost response).
- **Simultaneous events:** a new grant and a returning response in the same cycle are independent and both proceed.
- **Reset (any time, including mid-operation):**
  - Outstanding pipe entries are discarded; no `rvalid_o` is produced for them.
  - `ptr=0`, `err_o=0`, hold state cleared.

## Timing
- Grant is zero-cycle: `gnt_o` is combinational from `req_i` in the same cycle. A requester must hold its request fields stable while `req_i=1`.
- Read data is returned exactly `Latency` cycles after the grant cycle, on `rvalid_o[idx]` together with `rdata_o`.
- Throughput: one access per cycle, with back-to-back grants to different or the same requesters.
- Reset values:
  - `gnt_o=0`, `rvalid_o=0`, `ram_req_o=0`.
  - All other RAM outputs 0.
  - `err_o=0`.
  - `rdata_o` follows `ram_rdata_i`.
- Registers (`ptr`, pipe, `err`, hold state) use an asynchronous reset on `posedge rst_i`.

## Configuration
- **`SRAM_ARB_BURST_HOLD_EN` defined:**
  - After granting requester k, the arbiter keeps granting k while `req_i[k]` stays 1 and `hold_cnt < MaxHold`.
  - `hold_cnt` counts consecutive grants to k, starting at 1 on the first grant.
  - When `req_i[k]` drops or `hold_cnt` reaches `MaxHold`, normal round-robin resumes from k+1 and `hold_cnt` resets.
  - `MaxHold=1` behaves identically to the undefined case.
- **Undefined:** pure round-robin every cycle. The hold logic and `MaxHold` are unused.

## Test plan
- **Single requester read:** reset, then req0 read at addr 0x010 with RAM data 0xDEADBEEF and Latency=1 -> `gnt_o=01` in the same cycle; one cycle later `rvalid_o=01` and `rdata_o=0xDEADBEEF`; `err_o` stays 0.
- **Contention:** NumReq=2, both requesters reading continuously for 6 cycles from `ptr=0` -> grants alternate 01,10,01,10,01,10; `rvalid_o` follows the same sequence delayed by Latency.
- **Write then read:** req1 writes 0xA5A5A5A5 with mask 0xFFFF0000 to 0x020, then reads 0x020 -> the write cycle produces no `rvalid_o`; the read returns `rvalid_o=10` with RAM data 0xA5A50000 (model preloaded with 0).
- **Reset mid-flight:** Latency=3, grant a read, assert `rst_i` one cycle later -> no `rvalid_o` at any time; all outputs 0 during reset; `err_o` stays 0 even if the model still returns data after reset is released and the bench suppresses it.
- **Spurious response:** drive `ram_rvalid_i=1` with no read outstanding -> `err_o=1` the next cycle and it stays 1 until `rst_i`.
- **Burst hold (with macro, MaxHold=4):** both requesters requesting continuously -> grants 01,01,01,01,10,10,10,10,01...; without the macro -> strict alternation.
